// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: word width, RAM handshake state and the
// arbiter state encoding (exported so debug views can decode the FSM).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DGRANT = 2'b01,
    IGRANT = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle for mem_arbiter.
// slave  : the arbiter's view (takes cache requests and RAM status).
// master : the environment's view (caches plus RAM).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import cpu_types_pkg::*;

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;

  logic              err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between icache and dcache.
// One grant is registered at a time and held until the RAM reports ACCESS
// (or ERROR, or the granted cache withdraws its request). dcache wins ties.
// Optional build macro ARB_STARVE_EN adds a starvation guard: after
// STARVE_LIMIT consecutive d completions with i waiting, i is granted first.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic        CLK,
  input logic        RST,
  mem_arbiter_if.slave bus
);

  arb_state_t        state;
  arb_state_t        nextState;
  logic              err;
  logic              errSet;
  logic              dFirst;

  logic              ramRd;
  logic              ramWr;
  logic [ADDR_W-1:0] ramAddrMux;
  logic [DATA_W-1:0] ramStoreMux;
  logic              iStall;
  logic              dStall;

`ifdef ARB_STARVE_EN
  localparam int CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_cnt;
  logic            starved;
  logic            dDone;
  logic            iDone;

  assign starved = (starve_cnt == StarveMax);
  assign dDone   = (state == DGRANT) && (bus.ramstate == ACCESS);
  assign iDone   = (state == IGRANT) && (bus.ramstate == ACCESS);
  assign dFirst  = (bus.dREN | bus.dWEN) & ~(bus.iREN & starved);
`else
  assign dFirst  = bus.dREN | bus.dWEN;

  // STARVE_LIMIT has no effect without the guard; this empty block only
  // keeps the parameter elaborated so both builds share one port list.
  if (STARVE_LIMIT < 1) begin : g_limit_ignored
  end
`endif

  // State register, sticky error flag and (when guarded) the starvation count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      err   <= 1'b0;
`ifdef ARB_STARVE_EN
      starve_cnt <= '0;
`endif
    end else begin
      state <= nextState;
      if (errSet) begin
        err <= 1'b1;
      end
`ifdef ARB_STARVE_EN
      if (iDone || ((state == IDLE) && !bus.iREN)) begin
        starve_cnt <= '0;
      end else if (dDone && bus.iREN && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
`endif
    end
  end

  // Grant selection, RAM port steering and wait generation.
  always_comb begin
    nextState   = state;
    ramRd       = 1'b0;
    ramWr       = 1'b0;
    ramAddrMux  = '0;
    ramStoreMux = '0;
    iStall      = 1'b1;
    dStall      = 1'b1;
    errSet      = 1'b0;

    if (RST) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (dFirst) begin
            nextState = DGRANT;
          end else if (bus.iREN) begin
            nextState = IGRANT;
          end
        end

        DGRANT: begin
          ramAddrMux  = bus.daddr;
          ramStoreMux = bus.dstore;
          ramWr       = bus.dWEN;
          ramRd       = bus.dREN & ~bus.dWEN;
          dStall      = (bus.ramstate != ACCESS);
          if (bus.ramstate == ERROR) begin
            errSet = 1'b1;
          end
          if (!(bus.dREN || bus.dWEN) || (bus.ramstate == ACCESS) ||
              (bus.ramstate == ERROR)) begin
            nextState = IDLE;
          end
        end

        IGRANT: begin
          ramAddrMux = bus.iaddr;
          ramRd      = bus.iREN;
          iStall     = (bus.ramstate != ACCESS);
          if (bus.ramstate == ERROR) begin
            errSet = 1'b1;
          end
          if (!bus.iREN || (bus.ramstate == ACCESS) || (bus.ramstate == ERROR)) begin
            nextState = IDLE;
          end
        end

        default: begin
          nextState = IDLE;
        end
      endcase
    end
  end

  assign bus.ramREN   = ramRd;
  assign bus.ramWEN   = ramWr;
  assign bus.ramaddr  = ramAddrMux;
  assign bus.ramstore = ramStoreMux;
  assign bus.iwait    = iStall;
  assign bus.dwait    = dStall;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.err      = err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed cycle-by-cycle scenarios, then a
// randomized phase with independent i/d cache drivers, a latency-randomizing
// RAM device and a queue-based scoreboard checked by a separate monitor.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  typedef struct {
    bit          isWrite;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic CLK = 1'b0;
  logic RST;

  int vectors     = 0;
  int miscompares = 0;

  bit ramAuto  = 1'b0;
  bit sbEnable = 1'b0;

  txn_t dq[$];
  txn_t iq[$];

  logic [31:0] ramMem[128];
  logic [31:0] refMem[128];

  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  function automatic logic [31:0] seedWord(input int idx);
    return (32'(idx) * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: wait never dropped, expected completion", name);
  endtask

  task automatic idleInputs();
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramstate = FREE;
    bus.ramload  = '0;
  endtask

  task automatic applyStimulus(input logic iren, input logic [31:0] ia,
                               input logic dren, input logic dwen,
                               input logic [31:0] da, input logic [31:0] ds,
                               input ramstate_t rs, input logic [31:0] rl);
    @(posedge CLK);
    #1;
    bus.iREN     = iren;
    bus.iaddr    = ia;
    bus.dREN     = dren;
    bus.dWEN     = dwen;
    bus.daddr    = da;
    bus.dstore   = ds;
    bus.ramstate = rs;
    bus.ramload  = rl;
  endtask

  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge CLK);
      #1;
      idleInputs();
    end
  endtask

  task automatic resetDut();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    idleInputs();
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // RAM device: random BUSY latency, then one ACCESS cycle per strobe.
  task automatic ramResponder();
    bit busy = 1'b0;
    int left = 0;
    forever begin
      @(posedge CLK);
      #2;
      if (ramAuto) begin
        if (bus.ramREN || bus.ramWEN) begin
          if (!busy) begin
            busy = 1'b1;
            left = $urandom_range(0, 2);
          end
          if (left == 0) begin
            bus.ramstate = ACCESS;
            if (bus.ramWEN) ramMem[bus.ramaddr[8:2]] = bus.ramstore;
            else bus.ramload = ramMem[bus.ramaddr[8:2]];
            busy = 1'b0;
          end else begin
            bus.ramstate = BUSY;
            bus.ramload  = $urandom;
            left--;
          end
        end else begin
          bus.ramstate = FREE;
          bus.ramload  = $urandom;
          busy         = 1'b0;
        end
      end
    end
  endtask

  task automatic dDriver(input int n);
    txn_t e;
    int   idx;
    int   budget;
    int   gap;
    @(posedge CLK);
    #1;
    for (int t = 0; t < n; t++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        @(posedge CLK);
        #1;
      end
      idx       = 64 + $urandom_range(0, 63);
      e.addr    = 32'(idx) << 2;
      e.isWrite = 1'($urandom_range(0, 1));
      if (e.isWrite) begin
        e.data      = $urandom;
        refMem[idx] = e.data;
        bus.dWEN    = 1'b1;
        bus.dREN    = 1'($urandom_range(0, 1));
        bus.dstore  = e.data;
      end else begin
        e.data     = refMem[idx];
        bus.dREN   = 1'b1;
        bus.dWEN   = 1'b0;
        bus.dstore = $urandom;
      end
      bus.daddr = e.addr;
      dq.push_back(e);
      budget = 0;
      do begin
        @(negedge CLK);
        budget++;
      end while (bus.dwait && budget < 400);
      if (bus.dwait) reportTimeout("d_request_timeout");
      @(posedge CLK);
      #1;
      bus.dREN = 1'b0;
      bus.dWEN = 1'b0;
    end
  endtask

  task automatic iDriver(input int n);
    txn_t e;
    int   idx;
    int   budget;
    int   gap;
    @(posedge CLK);
    #1;
    for (int t = 0; t < n; t++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.iREN = 1'b0;
        @(posedge CLK);
        #1;
      end
      idx       = $urandom_range(0, 63);
      e.addr    = 32'(idx) << 2;
      e.isWrite = 1'b0;
      e.data    = refMem[idx];
      bus.iREN  = 1'b1;
      bus.iaddr = e.addr;
      iq.push_back(e);
      budget = 0;
      do begin
        @(negedge CLK);
        budget++;
      end while (bus.iwait && budget < 400);
      if (bus.iwait) reportTimeout("i_request_timeout");
      @(posedge CLK);
      #1;
      bus.iREN = 1'b0;
    end
  endtask

  // Scoreboard monitor: every completion pops and checks the oldest expectation.
  initial begin
    txn_t e;
    forever begin
      @(negedge CLK);
      if (sbEnable) begin
        if (!bus.dwait && !bus.iwait) begin
          checkOutput("both_waits_low", 32'(bus.iwait), 32'd1);
        end
        if (!bus.dwait) begin
          if (dq.size() == 0) begin
            reportTimeout("d_unexpected_completion");
          end else begin
            e = dq.pop_front();
            checkOutput("d_addr", bus.ramaddr, e.addr);
            checkOutput("d_wen", 32'(bus.ramWEN), 32'(e.isWrite));
            checkOutput("d_ren", 32'(bus.ramREN), 32'(!e.isWrite));
            if (e.isWrite) checkOutput("d_store", bus.ramstore, e.data);
            else checkOutput("d_load", bus.dload, e.data);
          end
        end
        if (!bus.iwait) begin
          if (iq.size() == 0) begin
            reportTimeout("i_unexpected_completion");
          end else begin
            e = iq.pop_front();
            checkOutput("i_addr", bus.ramaddr, e.addr);
            checkOutput("i_ren", 32'(bus.ramREN), 32'd1);
            checkOutput("i_wen", 32'(bus.ramWEN), 32'd0);
            checkOutput("i_load", bus.iload, e.data);
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dDone;
    int iSeen;
    int dBeforeI;

    for (int k = 0; k < 128; k++) begin
      ramMem[k] = seedWord(k);
      refMem[k] = seedWord(k);
    end
    RST = 1'b1;
    idleInputs();
    fork
      ramResponder();
    join_none

    $display("[TB] reset with both requests asserted");
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, FREE, 32'h0);
      @(negedge CLK);
      checkOutput("rst_ramREN", 32'(bus.ramREN), 32'd0);
      checkOutput("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
      checkOutput("rst_iwait", 32'(bus.iwait), 32'd1);
      checkOutput("rst_dwait", 32'(bus.dwait), 32'd1);
      checkOutput("rst_err", 32'(bus.err), 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("post_rst_ramaddr", bus.ramaddr, 32'h0);

    $display("[TB] icache read with two-cycle RAM latency");
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    @(negedge CLK);
    checkOutput("i_c0_ramREN", 32'(bus.ramREN), 32'd0);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
    @(negedge CLK);
    checkOutput("i_c1_ramREN", 32'(bus.ramREN), 32'd1);
    checkOutput("i_c1_ramaddr", bus.ramaddr, 32'h40);
    checkOutput("i_c1_iwait", 32'(bus.iwait), 32'd1);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
    @(negedge CLK);
    checkOutput("i_c2_iwait", 32'(bus.iwait), 32'd1);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'hDEADBEEF);
    @(negedge CLK);
    checkOutput("i_c3_iwait", 32'(bus.iwait), 32'd0);
    checkOutput("i_c3_iload", bus.iload, 32'hDEADBEEF);
    checkOutput("i_c3_dwait", 32'(bus.dwait), 32'd1);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    @(negedge CLK);
    checkOutput("i_c4_idle_ramREN", 32'(bus.ramREN), 32'd0);
    checkOutput("i_c4_idle_iwait", 32'(bus.iwait), 32'd1);
    idleCycles(3);

    $display("[TB] simultaneous i read and d write");
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h1234, FREE, 32'h0);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h1234, BUSY, 32'h0);
    @(negedge CLK);
    checkOutput("pri_ramWEN", 32'(bus.ramWEN), 32'd1);
    checkOutput("pri_ramREN", 32'(bus.ramREN), 32'd0);
    checkOutput("pri_ramaddr", bus.ramaddr, 32'h80);
    checkOutput("pri_ramstore", bus.ramstore, 32'h1234);
    checkOutput("pri_dwait_busy", 32'(bus.dwait), 32'd1);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h1234, ACCESS, 32'h0);
    @(negedge CLK);
    checkOutput("pri_dwait_access", 32'(bus.dwait), 32'd0);
    checkOutput("pri_iwait_access", 32'(bus.iwait), 32'd1);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    @(negedge CLK);
    checkOutput("pri_gap_ramREN", 32'(bus.ramREN), 32'd0);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'hCAFEF00D);
    @(negedge CLK);
    checkOutput("pri_i_ramREN", 32'(bus.ramREN), 32'd1);
    checkOutput("pri_i_ramaddr", bus.ramaddr, 32'h44);
    checkOutput("pri_i_ramstore", bus.ramstore, 32'h0);
    checkOutput("pri_i_iload", bus.iload, 32'hCAFEF00D);
    idleCycles(2);

    $display("[TB] write wins over read, then ERROR completion");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h90, 32'h55, FREE, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h90, 32'h55, ACCESS, 32'h0);
    @(negedge CLK);
    checkOutput("rw_ramWEN", 32'(bus.ramWEN), 32'd1);
    checkOutput("rw_ramREN", 32'(bus.ramREN), 32'd0);
    checkOutput("rw_dwait", 32'(bus.dwait), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h90, 32'h55, FREE, 32'h0);
    @(negedge CLK);
    checkOutput("rw_gap_ramWEN", 32'(bus.ramWEN), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h90, 32'h55, ERROR, 32'h0);
    @(negedge CLK);
    checkOutput("err_dwait", 32'(bus.dwait), 32'd1);
    checkOutput("err_before", 32'(bus.err), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    @(negedge CLK);
    checkOutput("err_set", 32'(bus.err), 32'd1);
    checkOutput("err_after_ramWEN", 32'(bus.ramWEN), 32'd0);
    idleCycles(3);
    @(negedge CLK);
    checkOutput("err_sticky", 32'(bus.err), 32'd1);
    resetDut();
    @(negedge CLK);
    checkOutput("err_cleared", 32'(bus.err), 32'd0);

    $display("[TB] abort of an i grant while BUSY");
    applyStimulus(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    applyStimulus(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
    @(negedge CLK);
    checkOutput("abort_granted", 32'(bus.ramREN), 32'd1);
    applyStimulus(1'b0, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
    @(negedge CLK);
    checkOutput("abort_same_cycle", 32'(bus.ramREN), 32'd0);
    checkOutput("abort_iwait", 32'(bus.iwait), 32'd1);
    applyStimulus(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
    @(negedge CLK);
    checkOutput("abort_idle_next", 32'(bus.ramREN), 32'd0);
    checkOutput("abort_idle_iwait", 32'(bus.iwait), 32'd1);
    applyStimulus(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
    @(negedge CLK);
    checkOutput("abort_regrant", 32'(bus.ramREN), 32'd1);
    idleCycles(2);

    $display("[TB] continuous d traffic with i pending");
    resetDut();
    dDone    = 0;
    iSeen    = 0;
    dBeforeI = -1;
    for (int c = 0; c < 40 && iSeen == 0; c++) begin
      applyStimulus(1'b1, 32'h4C, 1'b1, 1'b0, 32'hA0, 32'h0, ACCESS, 32'h0);
      @(negedge CLK);
      if (!bus.dwait) dDone++;
      if (!bus.iwait) begin
        iSeen    = 1;
        dBeforeI = dDone;
      end
    end
`ifdef ARB_STARVE_EN
    checkOutput("starve_i_granted", 32'(iSeen), 32'd1);
    checkOutput("starve_d_count", 32'(dBeforeI), 32'(LIMIT));
`else
    checkOutput("strict_no_igrant", 32'(iSeen), 32'd0);
    checkOutput("strict_d_count", 32'(dDone), 32'd20);
`endif
    idleCycles(2);

    $display("[TB] randomized traffic");
    resetDut();
    ramAuto  = 1'b1;
    sbEnable = 1'b1;
    fork
      iDriver(40);
      dDriver(40);
    join
    repeat (4) @(posedge CLK);
    sbEnable = 1'b0;
    ramAuto  = 1'b0;
    checkOutput("dq_drained", 32'(dq.size()), 32'd0);
    checkOutput("iq_drained", 32'(iq.size()), 32'd0);
    checkOutput("rand_err_clear", 32'(bus.err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
